decoder_pulse: RTL and testbench

Registered 2-to-4 decoder with a valid/ready input handshake and timed one-hot output pulses. Decodes a 2-bit code `{b1,b0}` into one-hot lines `d3..d0`, holds the line high for `HOLD` cycles, then inserts one all-zero gap cycle before accepting the next code. It sits on the receive side of the 4-to-2 encoder path and restores the line-select signals that the encoder compressed. It also keeps a wrapping count of decoded codes for debug.

---
 rtl/decoder_pulse_if.sv | 40 ++++
 rtl/decoder_pulse.sv | 96 +++++++++
 tb/tb_decoder_pulse.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_pulse_if.sv
// Handshake and output bundle for decoder_pulse.
// The master drives the code and valid and watches the one-hot lines. The slave is the decoder.
interface decoder_pulse_if;
  logic       in_valid;
  logic       in_ready;
  logic       b0;
  logic       b1;
  logic       d0;
  logic       d1;
  logic       d2;
  logic       d3;
  logic       out_valid;
  logic [7:0] dec_count;

  modport master (
    output in_valid,
    output b0,
    output b1,
    input  in_ready,
    input  d0,
    input  d1,
    input  d2,
    input  d3,
    input  out_valid,
    input  dec_count
  );

  modport slave (
    input  in_valid,
    input  b0,
    input  b1,
    output in_ready,
    output d0,
    output d1,
    output d2,
    output d3,
    output out_valid,
    output dec_count
  );
endinterface

// File: rtl/decoder_pulse.sv
// Registered 2-to-4 decoder with a valid/ready input handshake.
// An accepted code drives its one-hot line for HOLD cycles. One all-zero gap
// cycle follows before the next code is taken. dec_count is a wrapping debug
// count of accepted codes.
module decoder_pulse #(
  parameter int unsigned HOLD = 4  // pulse width in cycles, 1..255
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_pulse_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // The counter starts at HOLD-1. It is tested for zero in S_HOLD, so the
  // line stays high for exactly HOLD cycles after the accepting edge.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [3:0] d_q;
  logic       out_valid_q;
  logic [7:0] dec_count_q;

  function automatic logic [3:0] decode(input logic [1:0] code);
    logic [3:0] lines;
    lines = '0;
    case (code)
      2'b00:   lines = 4'b0001;
      2'b01:   lines = 4'b0010;
      2'b10:   lines = 4'b0100;
      default: lines = 4'b1000;
    endcase
    return lines;
  endfunction

  // Handshake FSM: accept in IDLE, hold the one-hot line, then one gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      hold_cnt    <= '0;
      dec_count_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            d_q         <= decode({bus.b1, bus.b0});
            out_valid_q <= 1'b1;
            hold_cnt    <= HOLD_LOAD;
            dec_count_q <= dec_count_q + 8'd1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt == '0) begin
            d_q         <= '0;
            out_valid_q <= 1'b0;
            state       <= S_GAP;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          d_q         <= '0;
          out_valid_q <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  // Ready depends only on state, so in_valid has no combinational path to in_ready.
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.d0        = d_q[0];
  assign bus.d1        = d_q[1];
  assign bus.d2        = d_q[2];
  assign bus.d3        = d_q[3];
  assign bus.out_valid = out_valid_q;
  assign bus.dec_count = dec_count_q;

  // Output invariants: exactly one line while valid, none otherwise.
  a_onehot_when_valid: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q |-> $onehot(d_q));
  a_quiet_when_invalid: assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid_q |-> (d_q == '0));

endmodule

// File: tb/tb_decoder_pulse.sv
// Bench for decoder_pulse. The main DUT uses HOLD=4 and is checked by a
// scoreboard-driven pulse monitor. A second DUT with HOLD=1 is checked directly.
module tb_decoder_pulse;

  localparam int unsigned HOLD_A = 4;

  typedef struct {
    logic [1:0] code;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  decoder_pulse_if ifa ();
  decoder_pulse_if ifb ();

  decoder_pulse #(.HOLD(HOLD_A)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  decoder_pulse #(.HOLD(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic [7:0] exp_cnt = '0;

  logic [3:0] dvec_a;
  logic [3:0] dvec_b;
  assign dvec_a = {ifa.d3, ifa.d2, ifa.d1, ifa.d0};
  assign dvec_b = {ifb.d3, ifb.d2, ifb.d1, ifb.d0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse monitor for DUT A. A rising out_valid pops the scoreboard.
  // Each pulse is then checked for line, count, width, gap and return to idle.
  bit         active   = 1'b0;
  bit         post_gap = 1'b0;
  int         len      = 0;
  logic [3:0] cur_lines;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      active   = 1'b0;
      post_gap = 1'b0;
      len      = 0;
    end else begin
      if (post_gap) begin
        chk("idle_ready", 32'(ifa.in_ready), 32'd1);
        post_gap = 1'b0;
      end
      if (ifa.out_valid && !active) begin
        if (sb_q.size() == 0) begin
          chk("spurious_pulse", 32'd1, 32'd0);
          cur_lines = dvec_a;
        end else begin
          e = sb_q.pop_front();
          cur_lines = 4'b0001 << e.code;
          chk("pulse_lines", 32'(dvec_a), 32'(cur_lines));
          chk("pulse_count", 32'(ifa.dec_count), 32'(e.cnt));
          chk("busy_ready", 32'(ifa.in_ready), 32'd0);
        end
        active = 1'b1;
        len    = 1;
      end else if (ifa.out_valid && active) begin
        len++;
        chk("hold_stable", 32'(dvec_a), 32'(cur_lines));
      end else begin
        chk("idle_lines", 32'(dvec_a), 32'd0);
        if (active) begin
          chk("pulse_len", 32'(len), 32'(HOLD_A));
          chk("gap_ready", 32'(ifa.in_ready), 32'd0);
          active   = 1'b0;
          post_gap = 1'b1;
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] code);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.code  = code;
    e.cnt   = exp_cnt;
    sb_q.push_back(e);
  endtask

  // Waits for in_ready on DUT A, presents one code for one edge, and logs the expectation.
  task automatic send_a(input logic [1:0] code);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (ifa.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    ifa.in_valid = 1'b1;
    {ifa.b1, ifa.b0} = code;
    push_exp(code);
    @(posedge clk); #2;
    ifa.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb_q.delete();
    exp_cnt = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic drain_a();
    repeat (HOLD_A + 4) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.b0 = 1'b0; ifa.b1 = 1'b0;
    ifb.in_valid = 1'b0; ifb.b0 = 1'b0; ifb.b1 = 1'b0;
    #1;
    chk("rst_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_lines", 32'(dvec_a), 32'd0);
    chk("rst_count", 32'(ifa.dec_count), 32'd0);
    chk("rst_ready", 32'(ifa.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // HOLD=1 instance: code 11, a single gap cycle, then code 00.
    ifb.in_valid = 1'b1; {ifb.b1, ifb.b0} = 2'b11;
    @(posedge clk); @(negedge clk);
    chk("h1_d3", 32'(dvec_b), 32'h8);
    chk("h1_valid", 32'(ifb.out_valid), 32'd1);
    chk("h1_busy", 32'(ifb.in_ready), 32'd0);
    ifb.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("h1_gap_lines", 32'(dvec_b), 32'd0);
    chk("h1_gap_valid", 32'(ifb.out_valid), 32'd0);
    chk("h1_gap_ready", 32'(ifb.in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("h1_idle_ready", 32'(ifb.in_ready), 32'd1);
    ifb.in_valid = 1'b1; {ifb.b1, ifb.b0} = 2'b00;
    @(posedge clk); @(negedge clk);
    chk("h1_d0", 32'(dvec_b), 32'h1);
    chk("h1_count", 32'(ifb.dec_count), 32'd2);
    ifb.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("h1_d0_end", 32'(dvec_b), 32'd0);

    // All four codes, one-cycle valid each.
    for (int c = 0; c < 4; c++) send_a(2'(c));
    drain_a();
    chk("count_after_4", 32'(ifa.dec_count), 32'd4);

    // Continuous valid with code 10 for 18 edges gives three accepts.
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #2;
        if (ifa.in_ready) begin got = 1'b1; break; end
      end
      if (!got) chk("ready_timeout", 32'd0, 32'd1);
    end
    ifa.in_valid = 1'b1; {ifa.b1, ifa.b0} = 2'b10;
    for (int k = 0; k < 3; k++) push_exp(2'b10);
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); @(negedge clk);
      chk("stream_ready", 32'(ifa.in_ready), ((i + 1) % 6 == 0) ? 32'd1 : 32'd0);
    end
    ifa.in_valid = 1'b0;
    chk("stream_count", 32'(ifa.dec_count), 32'(exp_cnt));
    drain_a();

    // Inputs toggling during HOLD are ignored.
    send_a(2'b01);
    for (int i = 0; i < 3; i++) begin
      ifa.in_valid = ~ifa.in_valid | 1'b1;
      {ifa.b1, ifa.b0} = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("hold_ready", 32'(ifa.in_ready), 32'd0);
      chk("hold_count", 32'(ifa.dec_count), 32'(exp_cnt));
      @(posedge clk); #2;
    end
    ifa.in_valid = 1'b0;
    drain_a();

    // Reset two cycles into a d3 pulse, then accept 01 on the first edge.
    send_a(2'b11);
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb_q.delete();
    exp_cnt = '0;
    #1;
    chk("mid_rst_d3", 32'(ifa.d3), 32'd0);
    chk("mid_rst_valid", 32'(ifa.out_valid), 32'd0);
    chk("mid_rst_count", 32'(ifa.dec_count), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    ifa.in_valid = 1'b1; {ifa.b1, ifa.b0} = 2'b01;
    push_exp(2'b01);
    @(negedge clk);
    chk("post_rst_quiet", 32'(ifa.out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("post_rst_d1", 32'(dvec_a), 32'h2);
    chk("post_rst_count", 32'(ifa.dec_count), 32'd1);
    ifa.in_valid = 1'b0;
    drain_a();

    // 256 accepts wrap dec_count to 0. The 257th gives 1.
    pulse_reset();
    for (int n = 0; n < 256; n++) send_a(2'(n % 4));
    drain_a();
    chk("wrap_zero", 32'(ifa.dec_count), 32'd0);
    send_a(2'b10);
    chk("wrap_one", 32'(ifa.dec_count), 32'd1);
    drain_a();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
